uart_rx_word: RTL and testbench
===============================

# uart_rx_word

Serial-to-parallel UART receiver that turns an 8N1 serial line back into 32-bit words for the processor bus. It is the receive-side counterpart of the word-wide UART transmitter (`uart_top`). Four consecutive bytes are assembled into one word and exposed through a memory-mapped read port with a valid/acknowledge flag. Framing errors and overruns are reported as sticky status flags.

## Interface
- `CLKS_PER_BIT`, default 10417: clock cycles per serial bit (100 MHz / 9600 baud); minimum 8.
- `RX_ADDR`, default 32'hFFFF_FFFF: bus address whose read acknowledges the current word.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `serial`  in  1  asynchronous UART line; idle high.
- `re`  in  1  bus read strobe, one cycle.
- `address`  in  32  bus address; qualifies `re`.
- `dataOut`  out  32  last completed word; first received byte in [31:24], last in [7:0].
- `valid`  out  1  `dataOut` holds an unacknowledged word.
- `overrun`  out  1  sticky; a word completed while `valid`=1.
- `frameErr`  out  1  sticky; a stop bit sampled low.

## Operation
- Input path: 2-flop synchronizer on `serial`; both flops reset to 1. All decisions use the synchronized line `rxs`.
- Bit timer: counts 0..CLKS_PER_BIT-1. Bit counter: 0..7. Byte counter: 0..3. Shift register: 8 bits, LSB first. Word register: 24 bits holding the partial word.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `rxs`=0 -> START, timer cleared.
  - START: at timer = CLKS_PER_BIT/2 - 1 (integer division), sample `rxs`. If 0 -> DATA with timer cleared. If 1, the event is a glitch -> IDLE with no state change.
  - DATA: each time timer = CLKS_PER_BIT-1, shift `rxs` in as the next bit (bit 0 first) and clear the timer. After the 8th sample -> STOP.
  - STOP: at timer = CLKS_PER_BIT-1, sample `rxs`, then -> IDLE.
    - 1: byte accepted. Byte counter increments, wrapping 3 -> 0.
    - 0: byte discarded, partial word discarded, byte counter -> 0, `frameErr` <= 1.
- Word completion: a 4th accepted byte completes the word {b0,b1,b2,b3}.
  - `valid`=0: load `dataOut`, set `valid`.
  - `valid`=1: the new word is dropped, `dataOut` is kept, `overrun` <= 1.
- Acknowledge: `re`=1 with `address`==RX_ADDR clears `valid`, `overrun` and `frameErr`. `dataOut` keeps its value. `re` to any other address has no effect.
- Acknowledge and word completion in the same cycle: the new word loads, `valid` stays 1, `overrun` is not set, `overrun`/`frameErr` are cleared. A framing error in the same cycle as an acknowledge leaves `frameErr`=1.
- There is no inter-byte timeout. A partial word persists indefinitely until it completes, a framing error occurs, or reset.

## Timing
- Reset values: `dataOut`=0, `valid`=0, `overrun`=0, `frameErr`=0. FSM in IDLE; all counters 0; synchronizer at 1. Reset mid-frame discards the partial byte and word.
- The synchronizer adds 2 cycles from a `serial` edge to `rxs`.
- Sample points are relative to the synchronized falling edge of the start bit:
  - Start bit: CLKS_PER_BIT/2 cycles after it.
  - Data bit k: CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT cycles after it.
  - Stop bit: CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after it.
- `valid`, `overrun` and `frameErr` update on the clock edge after the stop-bit sample.
- FSM returns to IDLE mid-stop-bit. A start bit beginning right after a nominal stop bit is detected, so back-to-back bytes are received.
- Acknowledge takes effect on the edge where `re` is sampled; flags read 0 on the next cycle.

## Test plan
Bench uses CLKS_PER_BIT=16.
- Reset released, line idle high for 200 cycles -> `valid`=`overrun`=`frameErr`=0, `dataOut`=0.
- Send bytes 0x12,0x34,0x56,0x78 back-to-back -> `dataOut`=32'h12345678, `valid`=1 one cycle after the 4th stop sample. Then `re` @ 32'hFFFF_FFFF -> `valid`=0, `dataOut` unchanged.
- Send 0x87654321 without acknowledge, then send 0x1E2D3C4B -> `dataOut` stays 32'h87654321, `overrun`=1. `re` at address 0 -> no change. `re` @ RX_ADDR -> all flags cleared.
- Send 0xAA, then 0xBB with stop bit forced low, then 0x1E,0x2D,0x3C,0x4B -> `frameErr`=1, `dataOut`=32'h1E2D3C4B (0xAA discarded).
- Pulse `serial` low for 4 cycles, then idle -> no byte received, byte counter unchanged, FSM back in IDLE.
- Assert `reset` low during bit 5 of the 3rd byte, release, then send 4 fresh bytes -> `dataOut` equals the fresh word, with no residue from the first two bytes.

Source files
------------

// File: rtl/uart_rx_word.sv
// uart_rx_word: 8N1 UART receiver that packs four consecutive bytes into a
// 32-bit word and exposes it through a memory-mapped read port.
//
// Bus handshake: `valid` rises when a fresh word lands in `dataOut`; the word
// is consumed by a one-cycle `re` strobe whose `address` equals RX_ADDR,
// which clears `valid`, `overrun` and `frameErr` on that same clock edge.
// `dataOut` is never cleared by an acknowledge.
module uart_rx_word #(
  parameter int          CLKS_PER_BIT = 10417,
  parameter logic [31:0] RX_ADDR      = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        serial,
  input  logic        re,
  input  logic [31:0] address,
  output logic [31:0] dataOut,
  output logic        valid,
  output logic        overrun,
  output logic        frameErr,
  output logic [1:0]  dbg_state,
  output logic [1:0]  dbg_byte_cnt
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic          sync1_q, rxs_q;
  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [23:0]   word_q, word_d;
  logic [31:0]   data_q, data_d;
  logic          valid_q, valid_d;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;
  logic          ack, word_done;

  assign ack = re && (address == RX_ADDR);

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= serial;
      rxs_q   <= sync1_q;
    end
  end

  // Receive FSM, byte/word assembly and status flag next-state logic.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    word_d      = word_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    word_done   = 1'b0;

    if (ack) begin
      valid_d     = 1'b0;
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!rxs_q) state_d = START;
      end
      START: begin
        if (timer_q == HALF) begin
          timer_d   = '0;
          bit_cnt_d = 3'd0;
          // A line back high at mid start bit was only a glitch.
          state_d   = rxs_q ? IDLE : DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        if (timer_q == LAST) begin
          timer_d = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STOP: begin
        if (timer_q == LAST) begin
          // Leave mid stop bit so a start bit right after it is caught.
          timer_d = '0;
          state_d = IDLE;
          if (rxs_q) begin
            if (byte_cnt_q == 2'd3) begin
              word_done  = 1'b1;
              byte_cnt_d = 2'd0;
              word_d     = '0;
            end else begin
              byte_cnt_d = byte_cnt_q + 2'd1;
              word_d     = {word_q[15:0], shift_q};
            end
          end else begin
            byte_cnt_d  = 2'd0;
            word_d      = '0;
            frame_err_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // An acknowledge in the completion cycle frees the slot for the new word.
    if (word_done) begin
      if (!valid_q || ack) begin
        data_d  = {word_q, shift_q};
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= 2'd0;
      shift_q     <= 8'd0;
      word_q      <= 24'd0;
      data_q      <= 32'd0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      word_q      <= word_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign dataOut      = data_q;
  assign valid        = valid_q;
  assign overrun      = overrun_q;
  assign frameErr     = frame_err_q;
  assign dbg_state    = state_q;
  assign dbg_byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_uart_rx_word.sv
// Bench for uart_rx_word: serial frames are driven bit by bit and the bus
// outputs are compared against a byte-queue model of the word protocol.
module tb_uart_rx_word;

  localparam int          CPB      = 16;
  localparam logic [31:0] RXA      = 32'hFFFF_FFFF;
  localparam logic [1:0]  DBG_IDLE = 2'd0;

  logic        clk = 1'b0;
  logic        reset, serial, re;
  logic [31:0] address;
  logic [31:0] dataOut;
  logic        valid, overrun, frameErr;
  logic [1:0]  dbg_state, dbg_byte_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_lat  = -1;

  // Reference model state.
  logic [7:0]  part_q[$];
  logic [31:0] exp_q[$];
  logic        exp_valid = 1'b0;
  logic        exp_ovr   = 1'b0;
  logic        exp_fe    = 1'b0;

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  uart_rx_word #(.CLKS_PER_BIT(CPB), .RX_ADDR(RXA)) dut (
    .clk(clk), .reset(reset), .serial(serial), .re(re), .address(address),
    .dataOut(dataOut), .valid(valid), .overrun(overrun), .frameErr(frameErr),
    .dbg_state(dbg_state), .dbg_byte_cnt(dbg_byte_cnt)
  );

  function automatic logic [31:0] exp_data();
    return (exp_q.size() > 0) ? exp_q[exp_q.size()-1] : 32'h0;
  endfunction

  task automatic model_reset();
    part_q.delete();
    exp_q.delete();
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    exp_fe    = 1'b0;
  endtask

  task automatic model_ack();
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    exp_fe    = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok);
    logic [31:0] w;
    if (!ok) begin
      part_q.delete();
      exp_fe = 1'b1;
    end else begin
      part_q.push_back(b);
      if (part_q.size() == 4) begin
        w = {part_q[0], part_q[1], part_q[2], part_q[3]};
        part_q.delete();
        if (exp_valid) exp_ovr = 1'b1;
        else begin
          exp_q.push_back(w);
          exp_valid = 1'b1;
        end
      end
    end
  endtask

  // Drive one 8N1 frame. ack_at / rst_at give the cycle (within the frame)
  // at which to pulse an acknowledge or pull reset; rise_at reports the cycle
  // at which `valid` was first observed rising during the frame.
  task automatic send_byte(input logic [7:0] b, input bit ok, input int ack_at,
                           input int rst_at, output int rise_at);
    logic prev;
    logic bitv;
    int   n;
    rise_at = -1;
    prev    = valid;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < CPB; c++) begin
        n = i * CPB + c;
        @(negedge clk);
        if (valid === 1'b1 && prev !== 1'b1 && rise_at < 0) rise_at = n;
        prev = valid;
        if (n == rst_at) begin
          reset  = 1'b0;
          serial = 1'b1;
          re     = 1'b0;
          return;
        end
        if (i == 0)     bitv = 1'b0;
        else if (i < 9) bitv = b[i-1];
        else            bitv = ok ? 1'b1 : (c >= 12);
        serial  = bitv;
        re      = (n == ack_at);
        address = (n == ack_at) ? RXA : 32'h0;
      end
    end
    re = 1'b0;
    if (ack_at >= 0) model_ack();
    model_byte(b, ok);
    if (!ok) repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    int r;
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], 1'b1, -1, -1, r);
  endtask

  task automatic do_ack(input logic [31:0] addr);
    @(negedge clk);
    re      = 1'b1;
    address = addr;
    @(negedge clk);
    re      = 1'b0;
    address = 32'h0;
    if (addr == RXA) model_ack();
  endtask

  task automatic test_reset();
    reset = 1'b0; serial = 1'b1; re = 1'b0; address = 32'h0;
    model_reset();
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (200) @(negedge clk);
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_checks++; if (frameErr !== 1'b0) begin n_fail++; $display("FAIL reset_frameErr: got %b want 0", frameErr); end
    n_checks++; if (dataOut !== 32'h0) begin n_fail++; $display("FAIL reset_dataOut: got %h want 0", dataOut); end
    n_checks++; if (dbg_byte_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_bytecnt: got %0d want 0", dbg_byte_cnt); end
    n_checks++; if (dbg_state !== DBG_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, DBG_IDLE); end
  endtask

  task automatic test_back_to_back();
    int r;
    send_byte(8'h12, 1'b1, -1, -1, r);
    send_byte(8'h34, 1'b1, -1, -1, r);
    send_byte(8'h56, 1'b1, -1, -1, r);
    n_checks++; if (valid !== exp_valid) begin n_fail++; $display("FAIL b2b_valid_early: got %b want %b", valid, exp_valid); end
    send_byte(8'h78, 1'b1, -1, -1, r);
    ack_lat = r;
    n_checks++; if (dataOut !== 32'h12345678) begin n_fail++; $display("FAIL b2b_data: got %h want 12345678", dataOut); end
    n_checks++; if (dataOut !== exp_data()) begin n_fail++; $display("FAIL b2b_model: got %h want %h", dataOut, exp_data()); end
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", valid); end
    // Stop sample lands 9.5 bit times after the start edge plus 2 sync cycles.
    n_checks++; if (r < 9 * CPB + CPB / 2 + 2 || r > 9 * CPB + CPB / 2 + 4) begin
      n_fail++; $display("FAIL b2b_latency: valid rose at cycle %0d want %0d..%0d", r, 9 * CPB + CPB / 2 + 2, 9 * CPB + CPB / 2 + 4);
    end
    do_ack(RXA);
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ack_valid: got %b want 0", valid); end
    n_checks++; if (dataOut !== 32'h12345678) begin n_fail++; $display("FAIL ack_data: got %h want 12345678", dataOut); end
  endtask

  task automatic test_overrun();
    send_word(32'h87654321);
    send_word(32'h1E2D3C4B);
    n_checks++; if (dataOut !== 32'h87654321) begin n_fail++; $display("FAIL ovr_data: got %h want 87654321", dataOut); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    n_checks++; if (valid !== exp_valid) begin n_fail++; $display("FAIL ovr_valid: got %b want %b", valid, exp_valid); end
    do_ack(32'h0);
    n_checks++; if (overrun !== exp_ovr || valid !== exp_valid) begin
      n_fail++; $display("FAIL ovr_wrong_addr: got ovr=%b valid=%b want ovr=%b valid=%b", overrun, valid, exp_ovr, exp_valid);
    end
    do_ack(RXA);
    n_checks++; if ({valid, overrun, frameErr} !== 3'b000) begin
      n_fail++; $display("FAIL ovr_ack: got v/o/f=%b want 000", {valid, overrun, frameErr});
    end
    n_checks++; if (dataOut !== exp_data()) begin n_fail++; $display("FAIL ovr_ack_data: got %h want %h", dataOut, exp_data()); end
  endtask

  task automatic test_frame_err();
    int r;
    send_byte(8'hAA, 1'b1, -1, -1, r);
    send_byte(8'hBB, 1'b0, -1, -1, r);
    n_checks++; if (frameErr !== 1'b1) begin n_fail++; $display("FAIL fe_flag: got %b want 1", frameErr); end
    n_checks++; if (dbg_byte_cnt !== 2'd0) begin n_fail++; $display("FAIL fe_bytecnt: got %0d want 0", dbg_byte_cnt); end
    send_word(32'h1E2D3C4B);
    n_checks++; if (dataOut !== 32'h1E2D3C4B) begin n_fail++; $display("FAIL fe_data: got %h want 1e2d3c4b", dataOut); end
    n_checks++; if (frameErr !== exp_fe || valid !== exp_valid) begin
      n_fail++; $display("FAIL fe_flags: got fe=%b v=%b want fe=%b v=%b", frameErr, valid, exp_fe, exp_valid);
    end
    do_ack(RXA);
    n_checks++; if (frameErr !== 1'b0) begin n_fail++; $display("FAIL fe_ack: got %b want 0", frameErr); end
  endtask

  task automatic test_glitch();
    int r;
    send_byte(8'h11, 1'b1, -1, -1, r);
    send_byte(8'h22, 1'b1, -1, -1, r);
    @(negedge clk); serial = 1'b0;
    repeat (4) @(negedge clk);
    serial = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    n_checks++; if (dbg_byte_cnt !== 2'(part_q.size())) begin n_fail++; $display("FAIL glitch_bytecnt: got %0d want %0d", dbg_byte_cnt, part_q.size()); end
    n_checks++; if (dbg_state !== DBG_IDLE) begin n_fail++; $display("FAIL glitch_state: got %0d want %0d", dbg_state, DBG_IDLE); end
    n_checks++; if (frameErr !== 1'b0) begin n_fail++; $display("FAIL glitch_fe: got %b want 0", frameErr); end
    send_byte(8'h33, 1'b1, -1, -1, r);
    send_byte(8'h44, 1'b1, -1, -1, r);
    n_checks++; if (dataOut !== 32'h11223344) begin n_fail++; $display("FAIL glitch_data: got %h want 11223344", dataOut); end
    do_ack(RXA);
  endtask

  task automatic test_reset_mid();
    int r;
    logic [31:0] w;
    send_byte(8'h5A, 1'b1, -1, -1, r);
    send_byte(8'hA5, 1'b1, -1, -1, r);
    send_byte(8'hC3, 1'b1, -1, 6 * CPB + CPB / 2, r);
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (dataOut !== 32'h0 || valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_clear: got %h v=%b want 0 v=0", dataOut, valid); end
    reset = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    w = $urandom;
    send_word(w);
    n_checks++; if (dataOut !== w) begin n_fail++; $display("FAIL rstmid_data: got %h want %h", dataOut, w); end
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_valid: got %b want 1", valid); end
    do_ack(RXA);
  endtask

  task automatic test_ack_collision();
    int r;
    logic [31:0] w1, w2;
    w1 = $urandom;
    w2 = $urandom;
    send_word(w1);
    for (int k = 3; k >= 1; k--) send_byte(w2[8*k +: 8], 1'b1, -1, -1, r);
    // Acknowledge lands on the exact edge where the word completes.
    send_byte(w2[7:0], 1'b1, ack_lat - 1, -1, r);
    n_checks++; if (dataOut !== w2) begin n_fail++; $display("FAIL coll_data: got %h want %h", dataOut, w2); end
    n_checks++; if (valid !== 1'b1 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL coll_flags: got v=%b o=%b want v=1 o=0", valid, overrun);
    end
    do_ack(RXA);
  endtask

  task automatic test_random();
    int   r;
    logic [7:0] b;
    bit   ok;
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 4; k++) begin
        b  = 8'($urandom);
        ok = ($urandom_range(0, 7) != 0);
        send_byte(b, ok, -1, -1, r);
      end
      n_checks++; if (dataOut !== exp_data()) begin n_fail++; $display("FAIL rand_data[%0d]: got %h want %h", it, dataOut, exp_data()); end
      n_checks++; if ({valid, overrun, frameErr} !== {exp_valid, exp_ovr, exp_fe}) begin
        n_fail++; $display("FAIL rand_flags[%0d]: got v/o/f=%b want %b", it, {valid, overrun, frameErr}, {exp_valid, exp_ovr, exp_fe});
      end
      if ($urandom_range(0, 1) == 1) begin
        do_ack(RXA);
        n_checks++; if ({valid, overrun, frameErr} !== 3'b000) begin
          n_fail++; $display("FAIL rand_ack[%0d]: got v/o/f=%b want 000", it, {valid, overrun, frameErr});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    test_ack_collision();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
